// File: rtl/posit_extract_pipe_if.sv
// posit_extract_pipe_if: handshake and data bundle for posit_extract_pipe.
//   Input side : in_valid, in_ready, in_posit[31:0], in_tag[TAG_BITS-1:0]
//   Output side: out_valid, out_ready, out_sign, out_scale (8b signed),
//                out_exponent[1:0], out_fraction[26:0], out_inf, out_zero,
//                out_tag[TAG_BITS-1:0]
//   slave  : decoder view (consumes in_*, produces out_*)
//   master : producer/consumer view surrounding the decoder
interface posit_extract_pipe_if #(
  parameter int unsigned TAG_BITS = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_posit;
  logic [TAG_BITS-1:0]     in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic signed [7:0]       out_scale;
  logic [1:0]              out_exponent;
  logic [26:0]             out_fraction;
  logic                    out_inf;
  logic                    out_zero;
  logic [TAG_BITS-1:0]     out_tag;

  modport slave (
    input  in_valid, in_posit, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_exponent, out_fraction,
           out_inf, out_zero, out_tag
  );

  modport master (
    output in_valid, in_posit, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_exponent, out_fraction,
           out_inf, out_zero, out_tag
  );
endinterface

// File: rtl/posit_extract_pipe.sv
// posit_extract_pipe: elastic pipelined decoder for 32-bit posits (ES=2) into
// sign / scale / exponent / fraction / inf / zero, with a sideband tag.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset, clears all valids and outputs
//   bus      - posit_extract_pipe_if.slave (valid/ready in, valid/ready out)
// Pipeline ranks: S1 raw posit -> S2 sign/abs/specials -> S3 regime length ->
// output register (extraction). Latency 3 accepts-to-valid.
// Option: define POSIT_EXTRACT_SKID_EN to insert a 2-entry skid FIFO at the
// input with a registered in_ready (latency 4, same throughput).
module posit_extract_pipe #(
  parameter int unsigned TAG_BITS = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  posit_extract_pipe_if.slave bus
);

  // Per-rank advance enables: a rank loads when it is empty or its
  // successor is loading.
  logic w_en_s1, w_en_s2, w_en_s3, w_en_out;

  logic                r_s1_valid;
  logic [31:0]         r_s1_posit;
  logic [TAG_BITS-1:0] r_s1_tag;

  logic                r_s2_valid;
  logic                r_s2_sign, r_s2_zero, r_s2_inf;
  logic [30:0]         r_s2_abs;
  logic [TAG_BITS-1:0] r_s2_tag;

  logic                r_s3_valid;
  logic                r_s3_sign, r_s3_zero, r_s3_inf;
  logic [30:0]         r_s3_abs;
  logic [4:0]          r_s3_m;
  logic [TAG_BITS-1:0] r_s3_tag;

  logic                r_out_valid;
  logic                r_out_sign;
  logic [7:0]          r_out_scale;
  logic [1:0]          r_out_exponent;
  logic [26:0]         r_out_fraction;
  logic                r_out_inf, r_out_zero;
  logic [TAG_BITS-1:0] r_out_tag;

  // Source feeding S1 (either the input port or the skid FIFO head).
  logic                w_src_valid;
  logic [31:0]         w_src_posit;
  logic [TAG_BITS-1:0] w_src_tag;

  assign w_en_out = !r_out_valid || bus.out_ready;
  assign w_en_s3  = !r_s3_valid  || w_en_out;
  assign w_en_s2  = !r_s2_valid  || w_en_s3;
  assign w_en_s1  = !r_s1_valid  || w_en_s2;

`ifdef POSIT_EXTRACT_SKID_EN
  logic [31:0]         r_fifo_posit [2];
  logic [TAG_BITS-1:0] r_fifo_tag   [2];
  logic                r_wr_ptr, r_rd_ptr;
  logic [1:0]          r_cnt;
  logic                r_in_ready;
  logic                w_push, w_pop;
  logic [1:0]          w_cnt_d;

  assign w_push  = bus.in_valid && r_in_ready;
  assign w_pop   = (r_cnt != 2'd0) && w_en_s1;
  assign w_cnt_d = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_posit[0] <= '0;
      r_fifo_posit[1] <= '0;
      r_fifo_tag[0]   <= '0;
      r_fifo_tag[1]   <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_cnt           <= 2'd0;
      r_in_ready      <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_posit[r_wr_ptr] <= bus.in_posit;
        r_fifo_tag[r_wr_ptr]   <= bus.in_tag;
        r_wr_ptr               <= !r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= !r_rd_ptr;
      r_cnt      <= w_cnt_d;
      // Registered ready: only drops when both entries will be occupied.
      r_in_ready <= (w_cnt_d != 2'd2);
    end
  end

  assign w_src_valid  = (r_cnt != 2'd0);
  assign w_src_posit  = r_fifo_posit[r_rd_ptr];
  assign w_src_tag    = r_fifo_tag[r_rd_ptr];
  assign bus.in_ready = r_in_ready;
`else
  // Holds in_ready low until the first clock edge after reset release.
  logic r_init;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_init <= 1'b0;
    else          r_init <= 1'b1;
  end

  assign w_src_valid  = bus.in_valid && r_init;
  assign w_src_posit  = bus.in_posit;
  assign w_src_tag    = bus.in_tag;
  assign bus.in_ready = r_init && w_en_s1;
`endif

  // S1: capture raw operand.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_posit <= '0;
      r_s1_tag   <= '0;
    end else if (w_en_s1) begin
      r_s1_valid <= w_src_valid;
      if (w_src_valid) begin
        r_s1_posit <= w_src_posit;
        r_s1_tag   <= w_src_tag;
      end
    end
  end

  // S2: sign, specials, magnitude. Only the low 31 bits of |p| matter; bit 31
  // is only set for NaR, which is flagged separately.
  logic [30:0] w_abs;
  assign w_abs = r_s1_posit[31] ? (~r_s1_posit[30:0] + 31'd1) : r_s1_posit[30:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_inf   <= 1'b0;
      r_s2_abs   <= '0;
      r_s2_tag   <= '0;
    end else if (w_en_s2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign <= r_s1_posit[31];
        r_s2_zero <= (r_s1_posit == 32'h0000_0000);
        r_s2_inf  <= (r_s1_posit == 32'h8000_0000);
        r_s2_abs  <= w_abs;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  // S3: regime run length m (1..31) of bits equal to abs[30].
  logic [4:0] w_m;
  logic       w_found;

  always_comb begin
    w_m     = 5'd31;
    w_found = 1'b0;
    for (int i = 29; i >= 0; i--) begin
      if (!w_found && (r_s2_abs[i] != r_s2_abs[30])) begin
        w_m     = 5'(30 - i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_valid <= 1'b0;
      r_s3_sign  <= 1'b0;
      r_s3_zero  <= 1'b0;
      r_s3_inf   <= 1'b0;
      r_s3_abs   <= '0;
      r_s3_m     <= '0;
      r_s3_tag   <= '0;
    end else if (w_en_s3) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_sign <= r_s2_sign;
        r_s3_zero <= r_s2_zero;
        r_s3_inf  <= r_s2_inf;
        r_s3_abs  <= r_s2_abs;
        r_s3_m    <= w_m;
        r_s3_tag  <= r_s2_tag;
      end
    end
  end

  // Output stage: drop regime + terminator, then exponent/fraction are the
  // top bits. A 6-bit shift amount lets m=31 shift everything out.
  logic [5:0]  w_sh;
  logic [30:0] w_shifted;
  logic [28:0] w_field;
  logic [7:0]  w_k;
  logic [7:0]  w_scale;
  logic        w_special;

  assign w_sh      = {1'b0, r_s3_m} + 6'd1;
  assign w_shifted = r_s3_abs << w_sh;
  assign w_field   = 29'(w_shifted >> 2);
  assign w_k       = r_s3_abs[30] ? ({3'd0, r_s3_m} - 8'd1) : (8'd0 - {3'd0, r_s3_m});
  assign w_scale   = (w_k << 2) + {6'd0, w_field[28:27]};
  assign w_special = r_s3_zero || r_s3_inf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid    <= 1'b0;
      r_out_sign     <= 1'b0;
      r_out_scale    <= '0;
      r_out_exponent <= '0;
      r_out_fraction <= '0;
      r_out_inf      <= 1'b0;
      r_out_zero     <= 1'b0;
      r_out_tag      <= '0;
    end else if (w_en_out) begin
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_sign     <= w_special ? 1'b0  : r_s3_sign;
        r_out_scale    <= w_special ? 8'd0  : w_scale;
        r_out_exponent <= w_special ? 2'd0  : w_field[28:27];
        r_out_fraction <= w_special ? 27'd0 : w_field[26:0];
        r_out_inf      <= r_s3_inf;
        r_out_zero     <= r_s3_zero;
        r_out_tag      <= r_s3_tag;
      end
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_sign     = r_out_sign;
  assign bus.out_scale    = r_out_scale;
  assign bus.out_exponent = r_out_exponent;
  assign bus.out_fraction = r_out_fraction;
  assign bus.out_inf      = r_out_inf;
  assign bus.out_zero     = r_out_zero;
  assign bus.out_tag      = r_out_tag;

endmodule
